// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: round-robin read scheduler draining bursts from NPORTS
// first-word-fall-through FIFOs into one registered valid/ready stream.
module fifo_rd_arbiter #(
    parameter int NPORTS    = 4,
    parameter int DWIDTH    = 32,
    parameter int SRC_W     = 2,
    parameter int MAX_BURST = 8
) (
    input  logic                     rclk,
    input  logic                     rrst_n,
    input  logic                     enable,
    input  logic [NPORTS-1:0]        rempty,
    input  logic [NPORTS-1:0]        arempty,
    input  logic [NPORTS*DWIDTH-1:0] rdata,
    output logic [NPORTS-1:0]        rinc,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DWIDTH-1:0]        m_data,
    output logic [SRC_W-1:0]         m_src,
    output logic                     m_last,
    output logic                     busy
);
    typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

    state_t            state, state_nx;
    logic [SRC_W-1:0]  g, last_grant, sel, idx;
    logic [7:0]        cnt;
    logic              found, load, last_word;
    logic [DWIDTH-1:0] words [NPORTS];

    always_comb begin
        for (int i = 0; i < NPORTS; i++) words[i] = rdata[i*DWIDTH +: DWIDTH];
    end

    // first non-empty port after the last grant, with wrap
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 1; k <= NPORTS; k++) begin
            idx = SRC_W'((int'(last_grant) + k) % NPORTS);
            if (!found && !rempty[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign load      = rrst_n && state == XFER && (!m_valid || m_ready) && !rempty[g];
    assign last_word = cnt == 8'(MAX_BURST - 1) || arempty[g];
    assign busy      = state != IDLE;

    always_comb begin
        rinc = '0;
        if (load) rinc[g] = 1'b1;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = enable && found ? XFER : IDLE;
            XFER:    state_nx = load && last_word ? DRAIN : XFER;
            DRAIN:   state_nx = !m_valid || m_ready ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            state      <= IDLE;
            g          <= '0;
            last_grant <= SRC_W'(NPORTS - 1);
            cnt        <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_src      <= '0;
            m_last     <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && enable && found) begin
                g   <= sel;
                cnt <= '0;
            end
            if (load) begin
                m_valid <= 1'b1;
                m_data  <= words[g];
                m_src   <= g;
                m_last  <= last_word;
                cnt     <= cnt + 8'd1;
                if (last_word) last_grant <= g;
            end else if (m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
        end
    end
endmodule

// File: doc/fifo_rd_arbiter.md
Name: fifo_rd_arbiter

Overview:
- Round-robin read-side scheduler that shares one downstream stream between NPORTS asynchronous FIFO read ports, all in the rclk domain.
- Grants one FIFO at a time and drains up to MAX_BURST words from it through a single registered output stage (valid/ready).
- Rotates priority when each burst ends.
- Drives each FIFO's rinc directly. Uses rempty and arempty to close the burst on the last word without popping an empty FIFO.

Parameters:
- NPORTS, 4, number of FIFO read ports (2..8)
- DWIDTH, 32, data width per FIFO
- SRC_W, 2, width of source index; must satisfy 2**SRC_W >= NPORTS
- MAX_BURST, 8, maximum words popped per grant (1..255)

Ports:
- rclk  in  1  read-domain clock
- rrst_n  in  1  synchronous active-low reset
- enable  in  1  permits new grants; sampled only in IDLE
- rempty  in  NPORTS  per-FIFO empty flag
- arempty  in  NPORTS  per-FIFO almost-empty flag (exactly one word left)
- rdata  in  NPORTS*DWIDTH  per-FIFO read data, first-word fall-through, valid whenever rempty[i]=0; port i occupies bits [i*DWIDTH +: DWIDTH]
- rinc  out  NPORTS  per-FIFO pop strobe, one-hot or zero
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accept
- m_data  out  DWIDTH  output word
- m_src  out  SRC_W  index of the source FIFO
- m_last  out  1  final word of the current burst
- busy  out  1  high when state is not IDLE

Behaviour:
- Reset (rrst_n=0 at a rclk edge):
  - state=IDLE; m_valid=0, m_data=0, m_src=0, m_last=0, busy=0; rinc=0 combinationally.
  - Burst counter=0; last-grant pointer=NPORTS-1, so port 0 has first priority.
  - A word held in the output register at reset is discarded.
- States: IDLE, XFER, DRAIN.
- IDLE:
  - If enable=1 and any rempty[i]=0, select the first i with rempty[i]=0, scanning from last_grant+1 with wrap.
  - Register grant g=i, clear the burst counter, go to XFER.
  - Arbitration costs exactly one cycle. No pop occurs in IDLE.
- XFER:
  - Load condition: (m_valid=0 or m_ready=1) and rempty[g]=0.
  - When loading, the same cycle asserts rinc[g]=1 and registers m_data<=rdata[g], m_src<=g, m_valid<=1, and increments the counter.
  - m_last<=1 when counter==MAX_BURST-1 or arempty[g]=1; otherwise 0.
  - A load with m_last=1 moves to DRAIN and sets last_grant<=g.
  - If rempty[g]=1 and no load is possible, stay in XFER. This cannot occur after a correct arempty sequence and is an assertion target.
  - When m_ready=1 with no new load, clear m_valid.
- DRAIN:
  - No pops.
  - When m_valid=1 and m_ready=1, clear m_valid and m_last and go to IDLE.
  - If m_valid is already 0, go to IDLE next cycle.
- Throughput: with m_ready held high, one word per cycle during XFER. Grant-to-grant overhead is 2 idle cycles (DRAIN + IDLE).
- rinc is never asserted while rempty[g]=1. At most one rinc bit is high per cycle.
- m_data, m_src and m_last stay stable while m_valid=1 and m_ready=0.
- enable deasserted mid-burst: the current burst completes normally; no new grant is issued.
- A new write to the granted FIFO during a burst after arempty was seen does not extend the burst. The data stays for a later grant.
- Counter width is 8 bits. It never wraps because the burst ends at MAX_BURST-1.

Test Plan:
1. Reset, then port 0 holds 3 words, m_ready=1, enable=1 -> IDLE 1 cycle; rinc[0] pulses 3 consecutive cycles; m_data equals the 3 words in order with m_src=0; m_last on word 3 only; busy falls 2 cycles after the last load.
2. Ports 0 and 2 each hold 20 words, MAX_BURST=8 -> bursts alternate 0,2,0,2,0,2 with sizes 8,8,8,8,4,4; m_last on the 8th/8th/8th/8th/4th/4th words.
3. m_ready held low for 5 cycles mid-burst on port 1 -> exactly one word popped, outputs held stable, no rinc during the stall; all words delivered unchanged after release.
4. Port 3 holds a single word (arempty=1 at grant) -> exactly one rinc[3] pulse, m_last=1 on that word, no pop while rempty[3]=1.
5. enable dropped during a port-1 burst with 6 words remaining -> burst finishes with m_last=1; then state stays IDLE with busy=0 while ports are non-empty; re-assert -> port 2 granted next if non-empty.
6. rrst_n pulsed low while m_valid=1 and m_ready=0 -> next cycle m_valid=0, rinc=0, state IDLE; first grant after reset goes to port 0.
